// File: rtl/debug_blink_pkg.sv
// Shared definitions for the LED debug blink link (transmitter and receiver).
// Frame layout: 32 slots per frame, slots 0..7 carry the debug byte LSB first,
// slots 8..31 are guard slots that must stay dark.
package debug_blink_pkg;

   localparam int DBG_SLOTS     = 32;
   localparam int DBG_DATA_BITS = 8;
   localparam int DBG_SLOT_W    = 5;

   typedef logic [DBG_SLOT_W-1:0] dbg_slot_t;

   localparam dbg_slot_t DBG_LAST_DATA_SLOT = dbg_slot_t'(DBG_DATA_BITS - 1);
   localparam dbg_slot_t DBG_LAST_SLOT      = dbg_slot_t'(DBG_SLOTS - 1);

   // True for slots that carry payload bits rather than guard time.
   function automatic logic isDataSlot(input dbg_slot_t slot);
      return slot <= DBG_LAST_DATA_SLOT;
   endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for bringing a single asynchronous bit
// into the clk domain. Both stages clear on the asynchronous reset.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // First stage may go metastable; second stage gives it a cycle to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/debug_blink_rx.sv
// Receive-side decoder for the LED debug blink pattern. Counts high samples
// of the synchronized blink line per slot, decodes each slot on tick, and
// rebuilds the debug byte once per 32-slot frame. Guard-slot activity is
// reported as a frame error at the end of the frame.
// Optional build macro DEBUG_BLINK_RX_PWM_CHECK_EN adds a pwm_err output that
// flags the line being high on two consecutive clk cycles.
module debug_blink_rx
   import debug_blink_pkg::*;
#(
   parameter int MIN_HITS = 1,
   parameter int HIT_W    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     led_in,
   output logic [DBG_DATA_BITS-1:0] data_out,
   output logic                     data_valid,
   output logic                     frame_err
`ifdef DEBUG_BLINK_RX_PWM_CHECK_EN
   ,
   output logic                     pwm_err
`endif
);

   localparam int              IDX_W       = $clog2(DBG_DATA_BITS);
   localparam logic [HIT_W-1:0] HITS_MAX   = '1;
   localparam logic [HIT_W-1:0] MIN_HITS_W = HIT_W'(MIN_HITS);

   logic                       w_ledSync;
   logic [HIT_W-1:0]           r_hits;
   logic [HIT_W-1:0]           w_hitsNext;
   logic                       w_slotBit;
   dbg_slot_t                  r_slot;
   logic [DBG_DATA_BITS-2:0]   r_shift;
   logic [DBG_DATA_BITS-1:0]   r_dataOut;
   logic                       r_dataValid;
   logic                       r_frameErr;
   logic                       r_guardHit;

   sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (led_in),
      .o_q (w_ledSync)
   );

   // Hit count including this cycle's sample (so the tick cycle counts toward
   // the closing slot), saturating instead of wrapping; decode the slot from it.
   always_comb begin
      w_hitsNext = r_hits;
      if (w_ledSync && (r_hits != HITS_MAX)) begin
         w_hitsNext = r_hits + 1'b1;
      end
      w_slotBit = (w_hitsNext >= MIN_HITS_W);
   end

   // Slot position and per-slot hit counter; every tick cycle closes a slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot <= DBG_LAST_SLOT;
         r_hits <= '0;
      end else if (tick) begin
         r_slot <= r_slot + 1'b1;
         r_hits <= '0;
      end else begin
         r_hits <= w_hitsNext;
      end
   end

   // Frame assembly: collect data bits, publish the byte after slot 7, and
   // track guard activity until the frame closes with slot 31.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift     <= '0;
         r_dataOut   <= '0;
         r_dataValid <= 1'b0;
         r_frameErr  <= 1'b0;
         r_guardHit  <= 1'b0;
      end else begin
         r_dataValid <= 1'b0;
         r_frameErr  <= 1'b0;
         if (tick) begin
            if (isDataSlot(r_slot)) begin
               if (r_slot == DBG_LAST_DATA_SLOT) begin
                  r_dataOut   <= {w_slotBit, r_shift};
                  r_dataValid <= 1'b1;
               end else begin
                  r_shift[r_slot[IDX_W-1:0]] <= w_slotBit;
               end
            end else begin
               if (w_slotBit) begin
                  r_guardHit <= 1'b1;
               end
               if (r_slot == DBG_LAST_SLOT) begin
                  r_frameErr <= r_guardHit | w_slotBit;
                  r_guardHit <= 1'b0;
               end
            end
         end
      end
   end

   assign data_out   = r_dataOut;
   assign data_valid = r_dataValid;
   assign frame_err  = r_frameErr;

`ifdef DEBUG_BLINK_RX_PWM_CHECK_EN
   logic r_ledPrev;
   logic r_pwmErr;

   // The transmitter never drives two high cycles in a row; flag it if seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ledPrev <= 1'b0;
         r_pwmErr  <= 1'b0;
      end else begin
         r_ledPrev <= w_ledSync;
         r_pwmErr  <= w_ledSync & r_ledPrev;
      end
   end

   assign pwm_err = r_pwmErr;
`endif

endmodule

// File: tb/tb_debug_blink_rx.sv
// Self-checking bench for debug_blink_rx: directed frames plus randomized
// slot lengths and blink patterns, compared every cycle against a frame-level
// model of the decoder.
module tb_debug_blink_rx;

   localparam int MIN_HITS = 3;
   localparam int HIT_W    = 4;
   localparam int HIT_MAX  = (1 << HIT_W) - 1;
   localparam int SLOT_LEN = 16;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       tick  = 1'b0;
   logic       ledIn = 1'b0;
   logic [7:0] dataOut;
   logic       dataValid;
   logic       frameErr;
`ifdef DEBUG_BLINK_RX_PWM_CHECK_EN
   logic       pwmErr;
`endif

   int         checks     = 0;
   int         failures   = 0;
   int         validCount = 0;
   int         errCount   = 0;
   int         pwmCount   = 0;
   logic [7:0] lastData   = '0;

   always #5 clk = ~clk;

   debug_blink_rx #(.MIN_HITS(MIN_HITS), .HIT_W(HIT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .led_in     (ledIn),
      .data_out   (dataOut),
      .data_valid (dataValid),
      .frame_err  (frameErr)
`ifdef DEBUG_BLINK_RX_PWM_CHECK_EN
      ,
      .pwm_err    (pwmErr)
`endif
   );

   // Frame-level model: the line is seen two clocks late, each slot decodes
   // from its clamped sample count, the byte appears after slot 7 and guard
   // activity is summarised after slot 31.
   int         mCnt;
   int         mSlot;
   int         mSat;
   bit         mBit;
   bit         mBits[32];
   bit         h1, h2, h3;
   logic       expValid = 1'b0;
   logic       expErr   = 1'b0;
   logic       expPwm   = 1'b0;
   logic [7:0] expData  = '0;

   always @(posedge clk) begin
      if (rst) begin
         mCnt = 0;
         mSlot = 31;
         for (int k = 0; k < 32; k++) mBits[k] = 1'b0;
         h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
         expValid = 1'b0; expErr = 1'b0; expPwm = 1'b0; expData = '0;
      end else begin
         expValid = 1'b0;
         expErr   = 1'b0;
         expPwm   = h2 & h3;
         if (h2) mCnt = mCnt + 1;
         if (tick) begin
            mSat = (mCnt > HIT_MAX) ? HIT_MAX : mCnt;
            mBit = (mSat >= MIN_HITS);
            mBits[mSlot] = mBit;
            if (mSlot == 7) begin
               expValid = 1'b1;
               for (int k = 0; k < 8; k++) expData[k] = mBits[k];
            end
            if (mSlot == 31) begin
               for (int k = 8; k < 32; k++) begin
                  expErr = expErr | mBits[k];
                  mBits[k] = 1'b0;
               end
            end
            mCnt = 0;
            mSlot = (mSlot + 1) % 32;
         end
         h3 = h2;
         h2 = h1;
         h1 = ledIn;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   // Every-cycle comparison against the model, plus pulse bookkeeping.
   always @(negedge clk) begin
      checkOutput("data_valid", int'(dataValid), rst ? 0 : int'(expValid));
      checkOutput("frame_err",  int'(frameErr),  rst ? 0 : int'(expErr));
      checkOutput("data_out",   int'(dataOut),   rst ? 0 : int'(expData));
`ifdef DEBUG_BLINK_RX_PWM_CHECK_EN
      checkOutput("pwm_err",    int'(pwmErr),    rst ? 0 : int'(expPwm));
      if (pwmErr === 1'b1) pwmCount++;
`endif
      if (dataValid === 1'b1) begin
         validCount++;
         lastData = dataOut;
      end
      if (frameErr === 1'b1) errCount++;
   end

   task automatic applyStimulus(input logic t, input logic l);
      tick  = t;
      ledIn = l;
      @(posedge clk);
      #2;
   endtask

   task automatic applyReset(input int cycles);
      rst   = 1'b1;
      tick  = 1'b0;
      ledIn = 1'b0;
      repeat (cycles) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // mode > 0: that many isolated highs (1 in 4); mode < 0: -mode solid highs.
   task automatic runSlot(input int mode, input int len);
      logic l;
      for (int i = 0; i < len; i++) begin
         l = 1'b0;
         if (mode > 0) l = ((i % 4) == 1) && ((i / 4) < mode);
         if (mode < 0) l = (i < -mode);
         applyStimulus(i == len - 1, l);
      end
   endtask

   task automatic runFrame(input logic [7:0] d, input int special, input int mode);
      for (int k = 0; k < 32; k++) begin
         if (k == special)
            runSlot(mode, (mode < 0) ? (-mode + 4) : SLOT_LEN);
         else
            runSlot((k < 8 && d[k]) ? 3 : 0, SLOT_LEN);
      end
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   int v0, e0, p0;

   task automatic snap();
      v0 = validCount;
      e0 = errCount;
      p0 = pwmCount;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset_data_out",   int'(dataOut),   0);
      checkOutput("reset_data_valid", int'(dataValid), 0);
      checkOutput("reset_frame_err",  int'(frameErr),  0);
      rst = 1'b0;

      // Pre-frame partial slot 31, then a clean A5 frame.
      runSlot(0, SLOT_LEN);
      snap();
      runFrame(8'hA5, -1, 0);
      checkOutput("a5_valid_count", validCount - v0, 1);
      checkOutput("a5_data",        int'(lastData),  'hA5);
      checkOutput("a5_no_err",      errCount - e0,   0);
`ifdef DEBUG_BLINK_RX_PWM_CHECK_EN
      checkOutput("a5_no_pwm",      pwmCount - p0,   0);
`endif

      // Guard slot 12 lit solid: frame error, byte unaffected.
      snap();
      runFrame(8'hA5, 12, -16);
      checkOutput("guard_err_count",   errCount - e0,   1);
      checkOutput("guard_valid_count", validCount - v0, 1);
      checkOutput("guard_data",        int'(lastData),  'hA5);

      // Threshold on slot 4: two hits stay 0, three hits decode as 1.
      runFrame(8'h00, 4, 2);
      checkOutput("min_hits_2", int'(lastData), 'h00);
      runFrame(8'h00, 4, 3);
      checkOutput("min_hits_3", int'(lastData), 'h10);

      // Reset in slot 5 of an FF frame discards it; the next frame is intact.
      snap();
      for (int k = 0; k < 5; k++) runSlot(3, SLOT_LEN);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, (i % 4) == 1);
      applyReset(2);
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("rst_no_valid",     validCount - v0, 0);
      checkOutput("rst_data_cleared", int'(dataOut),   0);
      runSlot(0, SLOT_LEN);
      snap();
      runFrame(8'hFF, -1, 0);
      checkOutput("ff_valid_count", validCount - v0, 1);
      checkOutput("ff_data",        int'(lastData),  'hFF);

      // Sixteen solid highs in slot 0 exceed the counter range; must still be 1.
      runFrame(8'h00, 0, -16);
      checkOutput("saturate_no_wrap", int'(lastData), 'h01);

`ifdef DEBUG_BLINK_RX_PWM_CHECK_EN
      snap();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("pwm_three_high", pwmCount - p0, 2);
`endif

      // Back-to-back ticks: one-cycle slots.
      for (int i = 0; i < 70; i++) applyStimulus(1'b1, $urandom_range(0, 1) == 1);

      // Random slot lengths, random line activity, occasional resets.
      for (int f = 0; f < 20; f++) begin
         for (int s = 0; s < 32; s++) begin
            int len;
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++)
               applyStimulus(i == len - 1, ($urandom % 3) == 0);
            if (($urandom % 60) == 0) applyReset($urandom_range(1, 3));
         end
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/debug_blink_rx.md
# debug_blink_rx

Receive-side decoder for the LED debug blink pattern. Samples the single-wire blink signal (the PWM'd LED drive, looped back or taken from a photodiode comparator) in the `clk` domain and reconstructs the 8-bit debug byte once per 32-slot frame. Flags frames with activity in the guard region. Used for loopback self-test of the debug LED path and for bench capture of debug bytes.

## Interface
Parameters:
- `MIN_HITS`, default 1: number of high samples within a slot required to decode that slot as 1.
- `HIT_W`, default 8: width of the per-slot high-sample counter. The counter saturates at 2^HIT_W-1.

Ports:
- `clk` in, 1: sole clock.
- `rst` in, 1: asynchronous, active-high reset.
- `tick` in, 1: single-`clk`-cycle slot strobe. Same strobe that advances the transmitter's slot counter, already in the `clk` domain.
- `led_in` in, 1: raw blink line. Asynchronous to `clk`.
- `data_out` out, 8: last decoded byte. Bit k is slot k.
- `data_valid` out, 1: one-cycle pulse when `data_out` updates.
- `frame_err` out, 1: one-cycle pulse at frame end if any guard slot (8..31) decoded as 1.

## Operation
- `led_in` passes through a 2-flop synchronizer; only the synchronized value is used.
- Slot index `slot` is 5 bits, reset to 31, incremented by 1 on each `tick`, with natural wrap 31→0.
  - The first `tick` after reset opens slot 0, matching the transmitter latching `debug[0]` on its first tick.
- Slot evaluation:
  - During a slot, `hits` counts `clk` cycles with synchronized input high, saturating.
  - On `tick`, the closing slot's bit = (`hits` >= `MIN_HITS`). `hits` then clears to 0 in that same cycle; the sample taken on the `tick` cycle itself counts toward the closing slot.
- Data slots 0..7:
  - The decoded bit is written into `shift[slot]`.
  - On the `tick` closing slot 7, `data_out` <= {bit7, `shift[6:0]`} and `data_valid` pulses.
- Guard slots 8..31:
  - A decoded 1 sets the sticky `guard_hit` flag.
  - On the `tick` closing slot 31, `frame_err` pulses if (`guard_hit` or the slot-31 bit), and `guard_hit` clears.
- The slot closed by the first `tick` after reset is slot 31, a partial pre-frame. It is evaluated normally, so it can raise `frame_err`.
- No lock/hunt state machine. Phase is fixed by sharing `tick` and `rst` with the transmitter.

## Timing
- Reset values:
  - `data_out`: 8'h00.
  - `data_valid`, `frame_err`, `hits`, `guard_hit`, `shift`, synchronizer flops: 0.
  - `slot`: 31.
- Input latency: 2 `clk` from `led_in` to the `hits` increment.
- `data_valid` and `frame_err` are registered. They assert in the `clk` cycle after the closing `tick` and last exactly 1 cycle.
- `data_out` holds until the next `data_valid`.
- Back-to-back `tick`s (consecutive cycles) are legal. A slot of length 1 sees at most 1 sample.
- A `tick` held high for N cycles counts as N ticks.
- `rst` mid-frame:
  - All state returns to reset values immediately.
  - A partially captured byte is discarded; no `data_valid`.
- `hits` saturation must not wrap. A slot longer than 2^HIT_W cycles still decodes as 1 if `MIN_HITS` was reached.

## Configuration
- `DEBUG_BLINK_RX_PWM_CHECK_EN` defined:
  - Adds output port `pwm_err` (1 bit, reset 0).
  - `pwm_err` pulses for 1 cycle whenever the synchronized input is high for 2 consecutive `clk` cycles. This is a 25%-duty violation, since the transmitter drives at most 1 high cycle in 4.
  - Checks run in all slots.
- Undefined: no `pwm_err` port and no checker logic.

## Structure
- Shared package `debug_blink_pkg`:
  - `DBG_SLOTS` = 32, `DBG_DATA_BITS` = 8, `DBG_SLOT_W` = 5.
  - Typedef `dbg_slot_t`.
  - Also used by the transmitter side.
- One sub-module `sync2`: generic 2-flop synchronizer with async active-high reset.
- Decoding and framing stay in `debug_blink_rx`.

## Test plan
- Loopback with the transmitter, `debug` = 8'hA5, tick every 16 clk → `data_valid` once per 32 ticks, `data_out` = 8'hA5, `frame_err` never.
- Force `led_in` high for all of slot 12 → `frame_err` pulses 1 cycle after the tick closing slot 31; `data_out` is unaffected.
- `MIN_HITS` = 3, 2 isolated high samples in slot 4, none elsewhere → `data_out` = 8'h00. Repeat with 3 samples → 8'h10.
- Assert `rst` for 2 cycles during slot 5 of a 8'hFF frame → no `data_valid` that frame. The next full frame yields 8'hFF.
- Slot length 300 clk, `HIT_W` = 8, input high throughout → `hits` saturates at 255, bit decodes as 1, no wrap.
- With `DEBUG_BLINK_RX_PWM_CHECK_EN`: `led_in` high for 3 consecutive clk → `pwm_err` pulses on 2 cycles. Normal transmitter PWM → `pwm_err` stays 0.
